feature_arbiter: RTL
====================

Name: feature_arbiter

Overview:
Shares the single downstream feature output (the feature list writer) between NUM_REQ parallel feature-detector lanes.
- Each lane presents (x, y, score) tuples indexed by the pixel indexer.
- The block grants lanes round-robin and serialises accepted features into one registered valid/ready stream.
- It enforces a per-frame feature cap and reports per-frame feature and drop counts at each frame boundary, using the delayed new-frame flag.

Parameters:
NUM_REQ, 4, number of detector lanes (2..16)
IND_WIDTH, 12, bits in each x/y index
SCORE_WIDTH, 8, bits in feature score
MAX_FEATURES, 256, features forwarded per frame before capping (>=1)
CNT_WIDTH, 16, width of feature/drop counters (saturating)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
frame_start  in  1  one-cycle pulse, new frame boundary (delayed new-frame flag)
req_valid  in  NUM_REQ  lane i has a feature
req_ready  out  NUM_REQ  lane i feature accepted this cycle
req_x  in  NUM_REQ*IND_WIDTH  lane i x at bits [i*IND_WIDTH +: IND_WIDTH]
req_y  in  NUM_REQ*IND_WIDTH  lane i y, same packing
req_score  in  NUM_REQ*SCORE_WIDTH  lane i score, same packing
out_valid  out  1  output feature valid
out_ready  in  1  downstream accepts
out_x  out  IND_WIDTH  feature x
out_y  out  IND_WIDTH  feature y
out_score  out  SCORE_WIDTH  feature score
out_src  out  $clog2(NUM_REQ)  granting lane index
frame_done  out  1  one-cycle pulse when a frame closes
frame_features  out  CNT_WIDTH  features forwarded in last closed frame
frame_drops  out  CNT_WIDTH  features dropped in last closed frame

Behaviour:
- Reset:
  - state IDLE; rr pointer 0; all outputs 0; internal feature_cnt and drop_cnt 0.
  - Reset mid-transfer discards the output register contents.
- FSM states:
  - IDLE: req_ready all 0. Leaves to ACTIVE on frame_start.
  - ACTIVE: forwards granted features.
  - CAPPED: accepts granted features and discards them.
- Grant (combinational): first asserted req_valid at or after rr pointer, searching cyclically. At most one req_ready high per cycle.
- req_ready[g] = grant AND state!=IDLE AND (CAPPED OR !out_valid OR out_ready).
- ACTIVE handshake on req_valid[g] && req_ready[g]:
  - Load out_x/out_y/out_score/out_src from lane g.
  - out_valid=1 next cycle (1-cycle latency, 1 feature/cycle sustained).
  - feature_cnt++.
- rr pointer advances to (g+1) mod NUM_REQ after every accepted handshake; it is unchanged otherwise.
- Output register:
  - out_valid and data held stable until out_ready.
  - out_valid clears on out_ready unless it is reloaded in the same cycle.
- Cap:
  - The handshake that makes feature_cnt == MAX_FEATURES moves the FSM to CAPPED next cycle.
  - In CAPPED, handshakes do not touch the output register and increment drop_cnt.
  - The output register still drains normally.
- frame_start, in ACTIVE or CAPPED:
  - Next cycle: frame_done=1; frame_features<=feature_cnt; frame_drops<=drop_cnt, including any handshake in the same cycle.
  - Counters cleared; state ACTIVE.
  - A handshake coincident with frame_start belongs to the closing frame.
  - The pending output register is unaffected.
- frame_start in IDLE: enters ACTIVE, frame_done stays 0.
- Counters saturate at 2^CNT_WIDTH-1 and never wrap.
- Lanes with req_valid deasserted are skipped with no idle cycle. A lane may drop req_valid without a handshake.

Optional Feature:
FEATURE_ARB_SCORE_THRESH_EN
- Defined:
  - Adds input score_thresh [SCORE_WIDTH].
  - A granted feature with score < score_thresh is still handshaken (req_ready high) but is discarded.
  - It counts in neither feature_cnt nor drop_cnt, does not load the output register, and still advances rr pointer.
- Undefined: port absent; all features treated as passing.

Test Plan:
- Single lane: rst, frame_start, lane1 offers (x=5,y=3,score=40) with out_ready=1 -> req_ready[1] same cycle; next cycle out_valid=1, out_x=5, out_y=3, out_score=40, out_src=1.
- Round-robin: all 4 lanes valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1; one transfer per cycle.
- Backpressure: out_ready=0 with out_valid=1 -> all req_ready=0; out_x/out_y/out_score stable; on out_ready=1, the next feature loads that same cycle with no bubble.
- Cap: MAX_FEATURES=4, lanes offer 7 features, then frame_start -> exactly 4 outputs; frame_done pulse with frame_features=4, frame_drops=3.
- Frame boundary collision: a handshake in the same cycle as frame_start -> counted in the closing frame's frame_features; the next frame starts at 0.
- Reset mid-operation: rst with out_valid=1 and state CAPPED -> next cycle out_valid=0, state IDLE, req_ready=0 until frame_start.

Source files
------------

// File: rtl/feature_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : feature_arbiter
//  Description : Round-robin arbiter that serialises (x, y, score) features
//                from NUM_REQ detector lanes into one registered valid/ready
//                stream, enforces a per-frame feature cap and reports
//                per-frame forwarded/dropped counts at each frame boundary.
//  Options     : FEATURE_ARB_SCORE_THRESH_EN - adds score_thresh input;
//                granted features scoring below it are accepted and silently
//                discarded (not counted, not forwarded).
//  Revision    : 1.0 - initial release
// ============================================================================
module feature_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IND_WIDTH    = 12,
    parameter int SCORE_WIDTH  = 8,
    parameter int MAX_FEATURES = 256,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              frame_start,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*IND_WIDTH-1:0]      req_x,
    input  logic [NUM_REQ*IND_WIDTH-1:0]      req_y,
    input  logic [NUM_REQ*SCORE_WIDTH-1:0]    req_score,
`ifdef FEATURE_ARB_SCORE_THRESH_EN
    input  logic [SCORE_WIDTH-1:0]            score_thresh,
`endif
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [IND_WIDTH-1:0]              out_x,
    output logic [IND_WIDTH-1:0]              out_y,
    output logic [SCORE_WIDTH-1:0]            out_score,
    output logic [$clog2(NUM_REQ)-1:0]        out_src,
    output logic                              frame_done,
    output logic [CNT_WIDTH-1:0]              frame_features,
    output logic [CNT_WIDTH-1:0]              frame_drops
);

    localparam int                   c_SRC_W     = $clog2(NUM_REQ);
    localparam logic [c_SRC_W-1:0]   c_LAST_LANE = c_SRC_W'(NUM_REQ - 1);
    localparam logic [CNT_WIDTH:0]   c_CAP_LIMIT = (CNT_WIDTH + 1)'(MAX_FEATURES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_CAPPED = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [c_SRC_W-1:0]      r_rr;
    logic [CNT_WIDTH-1:0]    r_feature_cnt;
    logic [CNT_WIDTH-1:0]    r_drop_cnt;

    logic                    w_gnt_found;
    logic [c_SRC_W-1:0]      w_gnt_idx;
    logic [c_SRC_W-1:0]      w_rr_next;
    logic                    w_accept_ok;
    logic                    w_hs;
    logic                    w_pass;
    logic                    w_fwd;
    logic                    w_drop;
    logic                    w_cap_hit;
    logic                    w_close;
    logic [IND_WIDTH-1:0]    w_sel_x;
    logic [IND_WIDTH-1:0]    w_sel_y;
    logic [SCORE_WIDTH-1:0]  w_sel_score;
    logic [CNT_WIDTH-1:0]    w_feat_next;
    logic [CNT_WIDTH-1:0]    w_drop_next;

    // Lane index `off` positions after `base`, wrapping at NUM_REQ
    // (NUM_REQ need not be a power of two).
    function automatic logic [c_SRC_W-1:0] wrap_idx(input logic [c_SRC_W-1:0] base,
                                                    input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return c_SRC_W'(s);
    endfunction

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Cyclic priority search: first valid lane at or after the rr pointer.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_gnt_found && req_valid[wrap_idx(r_rr, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = wrap_idx(r_rr, k);
            end
        end
    end

    // Payload of the granted lane.
    assign w_sel_x     = req_x[w_gnt_idx*IND_WIDTH +: IND_WIDTH];
    assign w_sel_y     = req_y[w_gnt_idx*IND_WIDTH +: IND_WIDTH];
    assign w_sel_score = req_score[w_gnt_idx*SCORE_WIDTH +: SCORE_WIDTH];

    // In CAPPED the output register is never loaded, so lanes are drained
    // regardless of downstream backpressure; in ACTIVE a transfer needs the
    // output register to be empty or emptying this cycle.
    assign w_accept_ok = (r_state != S_IDLE) &&
                         ((r_state == S_CAPPED) || !out_valid || out_ready);
    assign w_hs        = w_gnt_found && w_accept_ok;

`ifdef FEATURE_ARB_SCORE_THRESH_EN
    assign w_pass = (w_sel_score >= score_thresh);
`else
    assign w_pass = 1'b1;
`endif

    assign w_fwd  = w_hs && w_pass && (r_state == S_ACTIVE);
    assign w_drop = w_hs && w_pass && (r_state == S_CAPPED);

    // Running counts including this cycle's handshake, so a transfer that
    // coincides with frame_start is credited to the closing frame.
    assign w_feat_next = w_fwd  ? sat_inc(r_feature_cnt) : r_feature_cnt;
    assign w_drop_next = w_drop ? sat_inc(r_drop_cnt)    : r_drop_cnt;
    assign w_cap_hit   = w_fwd && ({1'b0, w_feat_next} >= c_CAP_LIMIT);
    assign w_close     = frame_start && (r_state != S_IDLE);

    assign w_rr_next = (w_gnt_idx == c_LAST_LANE) ? '0 : w_gnt_idx + 1'b1;

    // One-hot ready toward the granted lane only.
    always_comb begin
        req_ready = '0;
        if (w_hs) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a frame boundary always reopens in ACTIVE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_next = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (frame_start) begin
                    w_state_next = S_ACTIVE;
                end else if (w_cap_hit) begin
                    w_state_next = S_CAPPED;
                end
            end
            S_CAPPED: begin
                if (frame_start) begin
                    w_state_next = S_ACTIVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Round-robin pointer moves past the lane just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= '0;
        end else if (w_hs) begin
            r_rr <= w_rr_next;
        end
    end

    // Output holding register: load on forward, clear once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_score <= '0;
            out_src   <= '0;
        end else if (w_fwd) begin
            out_valid <= 1'b1;
            out_x     <= w_sel_x;
            out_y     <= w_sel_y;
            out_score <= w_sel_score;
            out_src   <= w_gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Per-frame counters and the frame-close report.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_feature_cnt  <= '0;
            r_drop_cnt     <= '0;
            frame_done     <= 1'b0;
            frame_features <= '0;
            frame_drops    <= '0;
        end else begin
            frame_done <= w_close;
            if (w_close) begin
                frame_features <= w_feat_next;
                frame_drops    <= w_drop_next;
                r_feature_cnt  <= '0;
                r_drop_cnt     <= '0;
            end else begin
                r_feature_cnt  <= w_feat_next;
                r_drop_cnt     <= w_drop_next;
            end
        end
    end

endmodule
`default_nettype wire
